// File: rtl/fpu_requester_if.sv
// Shared FPU operation encoding plus the two bundles the requester sits between:
// the CPU-facing request/response port and the FPU start/cmd_end/busy port.

package pa_fpu;
  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4
  } e_fpu_op;
endpackage

// CPU side: requests flow master -> slave, responses flow slave -> master.
interface fpu_req_if #(parameter int DEPTH = 4);
  logic                       req_valid;
  logic                       req_ready;
  pa_fpu::e_fpu_op            req_op;
  logic [31:0]                req_a;
  logic [31:0]                req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [31:0]                rsp_result;
  logic                       rsp_timeout;
  logic                       irq;
  logic [$clog2(DEPTH+1)-1:0] pending;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout, irq, pending
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_timeout, irq, pending
  );
endinterface

// FPU side: the requester is the master that starts operations.
interface fpu_bus_if;
  logic            fpu_start;
  logic [31:0]     fpu_a_operand;
  logic [31:0]     fpu_b_operand;
  pa_fpu::e_fpu_op fpu_operation;
  logic [31:0]     fpu_result;
  logic            fpu_cmd_end;
  logic            fpu_busy;

  modport master (
    output fpu_start, fpu_a_operand, fpu_b_operand, fpu_operation,
    input  fpu_result, fpu_cmd_end, fpu_busy
  );
  modport slave (
    input  fpu_start, fpu_a_operand, fpu_b_operand, fpu_operation,
    output fpu_result, fpu_cmd_end, fpu_busy
  );
endinterface

// File: rtl/fpu_requester.sv
// Initiator for the FPU start/cmd_end/busy handshake. Requests are queued in a
// small FIFO, issued one at a time, and results are returned in order on a
// valid/ready port. A watchdog turns a hung FPU into a qNaN abort response.

module fpu_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic      clk,
  input  logic      arst,
  fpu_req_if.slave  req,
  fpu_bus_if.master fpu
);
  import pa_fpu::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    e_fpu_op     op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  cmd_t          mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  // Occupancy seen one cycle late, so a fresh entry waits a cycle before issue.
  logic          nempty_q, nempty_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  e_fpu_op       op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic          to_q, to_d;
  logic          irq_q, irq_d;
  logic          push, pop, ready;
  cmd_t          cmd_in;

  assign ready  = (count_q < DEPTH_C);
  assign push   = req.req_valid && ready;
  assign cmd_in = '{op: req.req_op, a: req.req_a, b: req.req_b};

  assign req.req_ready   = ready;
  assign req.pending     = count_q;
  assign req.rsp_valid   = (state_q == RESP);
  assign req.rsp_result  = res_q;
  assign req.rsp_timeout = to_q;
  assign req.irq         = irq_q;

  // Start is decoded from state so an async reset drops it immediately.
  assign fpu.fpu_start     = (state_q == ISSUE);
  assign fpu.fpu_a_operand = a_q;
  assign fpu.fpu_b_operand = b_q;
  assign fpu.fpu_operation = op_q;

  // FIFO storage: data only, occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Next-state logic for the issue FSM, FIFO pointers and output latches.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    to_d     = to_q;
    irq_d    = 1'b0;
    pop      = 1'b0;
    nempty_d = (count_q != '0);

    case (state_q)
      IDLE: begin
        // A stale cmd_end or busy left over from before a reset blocks issue.
        if (nempty_q && (count_q != '0) && !fpu.fpu_busy && !fpu.fpu_cmd_end) begin
          state_d = ISSUE;
          pop     = 1'b1;
          a_d     = mem_q[rd_ptr_q].a;
          b_d     = mem_q[rd_ptr_q].b;
          op_d    = mem_q[rd_ptr_q].op;
          wd_d    = '0;
        end
      end
      ISSUE: begin
        if (fpu.fpu_cmd_end) begin
          res_d   = fpu.fpu_result;
          to_d    = 1'b0;
          state_d = DRAIN;
        end else if (wd_q == WD_LAST) begin
          res_d   = QNAN;
          to_d    = 1'b1;
          state_d = DRAIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!fpu.fpu_cmd_end && !fpu.fpu_busy) begin
          state_d = RESP;
          irq_d   = 1'b1;
        end
      end
      RESP: begin
        if (req.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nempty_q <= 1'b0;
      wd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= op_add;
      res_q    <= '0;
      to_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nempty_q <= nempty_d;
      wd_q     <= wd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      to_q     <= to_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_fpu_requester.sv
// Directed bench for fpu_requester with a small behavioural FPU model.

module tb_fpu_requester;
  import pa_fpu::*;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fpu_req_if #(.DEPTH(4)) rq ();
  fpu_bus_if              fb ();

  fpu_requester #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk  (clk),
    .arst (arst),
    .req  (rq),
    .fpu  (fb)
  );

  always #5 clk = ~clk;

  // FPU model: 5 cycles after seeing start, pulse cmd_end with the result.
  logic        mdl_busy = 1'b0;
  logic        mdl_act  = 1'b0;
  logic        stall    = 1'b0;
  logic        hang     = 1'b0;
  int          mdl_cnt  = 0;
  logic [31:0] ma, mb;

  assign fb.fpu_busy = mdl_busy | stall;

  function automatic logic [31:0] mdl_calc(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F8CCCCD) return 32'h40066666;
    if (a == 32'h7F800000 && b == 32'hFF800000) return 32'h7FC00000;
    if (a == 32'h00555555 && b == 32'h00555555) return 32'h00AAAAAA;
    return a ^ b;
  endfunction

  initial begin
    fb.fpu_cmd_end = 1'b0;
    fb.fpu_result  = '0;
    forever begin
      @(posedge clk); #2;
      if (!mdl_act) begin
        if (fb.fpu_start && !hang) begin
          mdl_act  = 1'b1;
          mdl_cnt  = 0;
          mdl_busy = 1'b1;
          ma       = fb.fpu_a_operand;
          mb       = fb.fpu_b_operand;
        end
      end else begin
        mdl_cnt++;
        if (mdl_cnt == 5) begin
          fb.fpu_cmd_end = 1'b1;
          fb.fpu_result  = mdl_calc(ma, mb);
        end else if (mdl_cnt == 6) begin
          fb.fpu_cmd_end = 1'b0;
          mdl_busy       = 1'b0;
          mdl_act        = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b);
    rq.req_valid = 1'b1;
    rq.req_op    = op;
    rq.req_a     = a;
    rq.req_b     = b;
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (!fb.fpu_start && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!fb.fpu_start) check({tag, "_start_wait"}, 32'(fb.fpu_start), 32'd1);
  endtask

  // Wait for a response, check it, hold it for 'hold' cycles, then accept it.
  task automatic get_rsp(input string tag, input logic [31:0] er, input logic et, input int hold);
    int k = 0;
    while (!rq.rsp_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rq.rsp_valid) begin
      check({tag, "_rsp_wait"}, 32'(rq.rsp_valid), 32'd1);
      return;
    end
    check({tag, "_result"}, rq.rsp_result, er);
    check({tag, "_timeout"}, 32'(rq.rsp_timeout), 32'(et));
    check({tag, "_irq_rise"}, 32'(rq.irq), 32'd1);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rq.rsp_valid), 32'd1);
      check({tag, "_hold_result"}, rq.rsp_result, er);
      check({tag, "_hold_irq"}, 32'(rq.irq), 32'd0);
      check({tag, "_hold_start"}, 32'(fb.fpu_start), 32'd0);
    end
    rq.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rq.rsp_ready = 1'b0;
    check({tag, "_accepted"}, 32'(rq.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt;
    rq.req_valid = 1'b0;
    rq.req_op    = op_add;
    rq.req_a     = '0;
    rq.req_b     = '0;
    rq.rsp_ready = 1'b0;

    // Reset state
    #1;
    check("rst_req_ready", 32'(rq.req_ready), 32'd1);
    check("rst_pending", 32'(rq.pending), 32'd0);
    check("rst_start", 32'(fb.fpu_start), 32'd0);
    check("rst_rsp_valid", 32'(rq.rsp_valid), 32'd0);
    check("rst_rsp_timeout", 32'(rq.rsp_timeout), 32'd0);
    check("rst_irq", 32'(rq.irq), 32'd0);
    check("rst_rsp_result", rq.rsp_result, 32'd0);
    check("rst_a_operand", fb.fpu_a_operand, 32'd0);
    check("rst_b_operand", fb.fpu_b_operand, 32'd0);
    check("rst_operation", 32'(fb.fpu_operation), 32'(op_add));
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    @(posedge clk); #1;

    // 1: single add, issue latency and pass-through operands
    push(op_add, 32'h3F800000, 32'h3F8CCCCD);
    check("t1_start_n", 32'(fb.fpu_start), 32'd0);
    check("t1_pending_n", 32'(rq.pending), 32'd1);
    @(posedge clk); #1;
    check("t1_start_n1", 32'(fb.fpu_start), 32'd0);
    @(posedge clk); #1;
    check("t1_start_n2", 32'(fb.fpu_start), 32'd1);
    check("t1_a_operand", fb.fpu_a_operand, 32'h3F800000);
    check("t1_b_operand", fb.fpu_b_operand, 32'h3F8CCCCD);
    check("t1_operation", 32'(fb.fpu_operation), 32'(op_add));
    check("t1_pending_pop", 32'(rq.pending), 32'd0);
    get_rsp("t1", 32'h40066666, 1'b0, 2);

    // 2: fill the FIFO while the FPU is busy, fifth push refused
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(op_mul, 32'h10 + i, 32'h100);
    rq.req_valid = 1'b1;
    rq.req_a     = 32'h14;
    rq.req_b     = 32'h100;
    check("t2_ready_full", 32'(rq.req_ready), 32'd0);
    check("t2_pending_full", 32'(rq.pending), 32'd4);
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    check("t2_pending_after5", 32'(rq.pending), 32'd4);
    repeat (3) @(posedge clk);
    #1 check("t2_start_stalled", 32'(fb.fpu_start), 32'd0);
    stall = 1'b0;
    get_rsp("t2_0", 32'h110, 1'b0, 2);
    get_rsp("t2_1", 32'h111, 1'b0, 2);
    get_rsp("t2_2", 32'h112, 1'b0, 2);
    get_rsp("t2_3", 32'h113, 1'b0, 2);
    check("t2_pending_empty", 32'(rq.pending), 32'd0);

    // 3: response back-pressure with a second request queued
    stall = 1'b1;
    push(op_sub, 32'h20, 32'h200);
    push(op_sub, 32'h21, 32'h200);
    stall = 1'b0;
    get_rsp("t3_0", 32'h220, 1'b0, 11);
    get_rsp("t3_1", 32'h221, 1'b0, 2);

    // 4: hung FPU, watchdog abort after 16 ISSUE cycles
    hang = 1'b1;
    push(op_div, 32'h30, 32'h300);
    wait_start("t4");
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!fb.fpu_start) break;
      cnt++;
    end
    check("t4_issue_cycles", 32'(cnt), 32'd16);
    get_rsp("t4", 32'h7FC00000, 1'b1, 2);
    hang = 1'b0;

    // 5: asynchronous reset mid-ISSUE with three queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(op_add, 32'h50 + i, 32'h500);
    stall = 1'b0;
    wait_start("t5");
    check("t5_pending_issue", 32'(rq.pending), 32'd3);
    @(posedge clk); #1;
    #2 arst = 1'b0;
    #1;
    check("t5_start_async", 32'(fb.fpu_start), 32'd0);
    check("t5_pending_async", 32'(rq.pending), 32'd0);
    check("t5_ready_async", 32'(rq.req_ready), 32'd1);
    check("t5_rsp_valid_async", 32'(rq.rsp_valid), 32'd0);
    check("t5_result_async", rq.rsp_result, 32'd0);
    check("t5_a_operand_async", fb.fpu_a_operand, 32'd0);
    @(posedge clk); #1;
    arst = 1'b1;
    push(op_add, 32'h40, 32'h400);
    get_rsp("t5_new", 32'h440, 1'b0, 2);
    check("t5_pending_end", 32'(rq.pending), 32'd0);

    // 6: special values pass through unmodified
    push(op_add, 32'h7F800000, 32'hFF800000);
    push(op_add, 32'h00555555, 32'h00555555);
    get_rsp("t6_inf", 32'h7FC00000, 1'b0, 2);
    get_rsp("t6_sub", 32'h00AAAAAA, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
